// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared ALU control codes, opcodes and branch funct3 encodings.
package alu_issue_ctrl_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: maps opcode/funct3/funct7b5 to ALU control, operand-B select, branch and illegal flags.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_ctrl,
    output logic       o_use_imm,
    output logic       o_is_branch,
    output logic       o_illegal
);
    logic w_mem, w_op, w_op_imm, w_arith, w_f3_ok, w_br_ok;
    logic [2:0] w_arith_ctrl;
    assign w_mem    = (i_opcode == OPC_LOAD) | (i_opcode == OPC_STORE);
    assign w_op     = i_opcode == OPC_OP;
    assign w_op_imm = i_opcode == OPC_OP_IMM;
    assign w_arith  = w_op | w_op_imm;
    assign w_f3_ok  = (i_funct3 == 3'b000) | (i_funct3 == 3'b010) | (i_funct3 == 3'b110) | (i_funct3 == 3'b111);
    assign w_br_ok  = (i_funct3 != 3'b010) & (i_funct3 != 3'b011);
    assign o_is_branch = i_opcode == OPC_BRANCH;
    assign o_use_imm   = w_mem | w_op_imm;
    assign o_illegal   = ~(w_mem | (o_is_branch & w_br_ok) | (w_arith & w_f3_ok));
    // funct7b5 only selects SUB for register-register arithmetic
    assign w_arith_ctrl = (i_funct3 == 3'b010) ? ALU_SLT :
                          (i_funct3 == 3'b110) ? ALU_OR  :
                          (i_funct3 == 3'b111) ? ALU_AND :
                          (w_op & i_funct7b5)  ? ALU_SUB : ALU_ADD;
    assign o_alu_ctrl = o_illegal   ? ALU_ADD :
                        o_is_branch ? ALU_SUB :
                        w_arith     ? w_arith_ctrl : ALU_ADD;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: two-stage issue pipeline driving an external combinational ALU and resolving branches.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_branch,
    output logic            out_taken,
    output logic            out_illegal
);
    logic [2:0] w_ctrl, r_funct3;
    logic w_use_imm, w_is_branch, w_illegal, w_accept, w_s1_adv, w_lt, w_ltu, w_cond;
    logic r_s1_valid, r_branch, r_illegal;
    alu_op_decode u_decode (
        .i_opcode    (in_opcode),
        .i_funct3    (in_funct3),
        .i_funct7b5  (in_funct7b5),
        .o_alu_ctrl  (w_ctrl),
        .o_use_imm   (w_use_imm),
        .o_is_branch (w_is_branch),
        .o_illegal   (w_illegal)
    );
    assign w_s1_adv = r_s1_valid & (~out_valid | out_ready);
    assign in_ready = ~r_s1_valid | w_s1_adv;
    assign w_accept = in_valid & in_ready;
    assign w_lt     = $signed(alu_a) < $signed(alu_b);
    assign w_ltu    = alu_a < alu_b;
    assign w_cond   = (r_funct3 == F3_BEQ)  ? alu_zero  :
                      (r_funct3 == F3_BNE)  ? ~alu_zero :
                      (r_funct3 == F3_BLT)  ? w_lt      :
                      (r_funct3 == F3_BGE)  ? ~w_lt     :
                      (r_funct3 == F3_BLTU) ? w_ltu     : ~w_ltu;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_funct3    <= 3'b000;
            r_branch    <= 1'b0;
            r_illegal   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= ALU_ADD;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_branch  <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a     <= w_illegal ? '0 : in_rs1;
                alu_b     <= w_illegal ? '0 : (w_use_imm ? in_imm : in_rs2);
                alu_ctrl  <= w_ctrl;
                r_funct3  <= in_funct3;
                r_branch  <= w_is_branch;
                r_illegal <= w_illegal;
            end
            r_s1_valid <= w_accept | (r_s1_valid & ~w_s1_adv);
            // a draining output and an advancing stage 1 share the edge: overwrite, no bubble
            if (w_s1_adv) begin
                out_valid   <= 1'b1;
                out_result  <= r_illegal ? '0 : alu_result;
                out_branch  <= r_branch;
                out_illegal <= r_illegal;
                out_taken   <= r_branch & ~r_illegal & w_cond;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench with an ALU model and an instruction-level reference model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready, in_funct7b5 = 1'b0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0, alu_ctrl;
    logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0, alu_a, alu_b, alu_result, out_result;
    logic        alu_zero, out_valid, out_ready = 1'b1, out_branch, out_taken, out_illegal;
    typedef struct {
        logic [31:0] res;
        logic        br, tk, il;
    } exp_t;
    exp_t q[$];
    int cmp_cnt = 0, err_cnt = 0, n_acc = 0, ready_mode = 1;
    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_branch(out_branch), .out_taken(out_taken), .out_illegal(out_illegal)
    );
    always #5 clk = ~clk;
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b101: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = alu_result == 32'd0;
    function automatic exp_t model(logic [6:0] op, logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
        exp_t e;
        logic [31:0] y;
        e.res = '0; e.br = (op == 7'h63); e.tk = 1'b0; e.il = 1'b0;
        y = (op == 7'h33) ? b : imm;
        case (op)
            7'h03, 7'h23: e.res = a + imm;
            7'h63: begin
                e.res = a - b;
                case (f3)
                    3'd0: e.tk = (a == b);
                    3'd1: e.tk = (a != b);
                    3'd4: e.tk = $signed(a) < $signed(b);
                    3'd5: e.tk = $signed(a) >= $signed(b);
                    3'd6: e.tk = a < b;
                    3'd7: e.tk = a >= b;
                    default: e.il = 1'b1;
                endcase
            end
            7'h33, 7'h13: begin
                case (f3)
                    3'd0: e.res = (op == 7'h33 && f7) ? a - y : a + y;
                    3'd2: e.res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd6: e.res = a | y;
                    3'd7: e.res = a & y;
                    default: e.il = 1'b1;
                endcase
            end
            default: e.il = 1'b1;
        endcase
        if (e.il) begin
            e.res = '0;
            e.tk = 1'b0;
        end
        return e;
    endfunction
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic send(logic [6:0] op, logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
        in_rs1 = a; in_rs2 = b; in_imm = imm;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(op, f3, f7, a, b, imm));
                n_acc++;
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        cmp_cnt++; err_cnt++;
        $display("FAIL send_timeout: in_ready never high for opcode %h", op);
        in_valid = 1'b0;
    endtask
    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
        chk("drain_pending", q.size(), 0);
        @(posedge clk); #1;
    endtask
    initial forever begin
        @(posedge clk); #1;
        out_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
    end
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                cmp_cnt++;
                if (q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL out_stale: got result %h with nothing pending", out_result);
                end else begin
                    e = q.pop_front();
                    if (out_result !== e.res || out_branch !== e.br || out_taken !== e.tk || out_illegal !== e.il) begin
                        err_cnt++;
                        $display("FAIL out_entry: got res=%h br=%b tk=%b il=%b want res=%h br=%b tk=%b il=%b",
                                 out_result, out_branch, out_taken, out_illegal, e.res, e.br, e.tk, e.il);
                    end
                end
            end
        end
    end
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n0;
        logic [6:0] ops [7];
        ops = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h7f, 7'h63};
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        send(7'h33, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0);
        chk("sub_ctrl", alu_ctrl, 3'b001);
        @(posedge clk); #1;
        chk("sub_lat_valid", out_valid, 1);
        chk("sub_lat_result", out_result, 7);
        send(7'h13, 3'd0, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF);
        chk("addi_ctrl", alu_ctrl, 3'b000);
        chk("addi_b", alu_b, 32'hFFFFFFFF);
        send(7'h63, 3'd4, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        send(7'h63, 3'd6, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        send(7'h63, 3'd0, 1'b0, 32'h55, 32'h55, 32'd0);
        drain();
        ready_mode = 0;
        repeat (2) @(posedge clk); #1;
        n0 = n_acc;
        fork
            for (int i = 0; i < 4; i++) send(7'h33, 3'd0, 1'b0, i * 100 + 1, i, 32'd0);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_accepted", n_acc - n0, 2);
                @(posedge clk);
                ready_mode = 1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_stream_valid", out_valid, 1);
                end
            end
        join
        drain();
        send(7'h7f, 3'd0, 1'b0, 32'h1234, 32'h5678, 32'h9);
        send(7'h33, 3'd7, 1'b0, 32'hF0F0, 32'hFF00, 32'd0);
        drain();
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(ops[$urandom_range(0, 6)] ^ (($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0),
                 3'($urandom_range(0, 7)), 1'($urandom), a, b, $urandom);
        end
        ready_mode = 1;
        drain();
        ready_mode = 0;
        repeat (2) @(posedge clk); #1;
        send(7'h33, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0);
        send(7'h33, 3'd7, 1'b0, 32'd3, 32'd4, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_alu_ctrl", alu_ctrl, 0);
        q.delete();
        ready_mode = 1;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send(7'h03, 3'd2, 1'b0, 32'h100, 32'd0, 32'h20);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
